// File: rtl/dm_mem_resp.sv
// Debug-memory response stage: hart handshake state, abstract-command FSM, data registers
// and the registered read-data mux that answers each request one cycle later.
module dm_mem_resp #(
    parameter int unsigned BusWidth    = 32,
    parameter int unsigned DataCount   = 2,
    parameter int unsigned ProgBufSize = 8,
    parameter int unsigned AbsCmdWords = 10,
    parameter int unsigned DataAddr    = 'h380,
    localparam int unsigned IdxW       = (DataCount > 1) ? $clog2(DataCount) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      wr_halted_en,
    input  logic                      wr_going_en,
    input  logic                      wr_resuming_en,
    input  logic                      wr_exception_en,
    input  logic                      wr_data_en,
    input  logic [BusWidth-1:0]       wr_data_addr_i,
    input  logic [BusWidth-1:0]       wdata_i,
    input  logic                      rd_where_en,
    input  logic                      rd_data_en,
    input  logic                      rd_prog_en,
    input  logic                      rd_abs_cmd_en,
    input  logic                      rd_flags_en,
    input  logic [BusWidth-1:0]       rd_addr_i,
    input  logic                      cmd_go_i,
    input  logic                      resumereq_i,
    input  logic                      dmi_data_we_i,
    input  logic [IdxW-1:0]           dmi_data_idx_i,
    input  logic [31:0]               dmi_wdata_i,
    input  logic [32*ProgBufSize-1:0] progbuf_i,
    input  logic [32*AbsCmdWords-1:0] abs_cmd_i,
    output logic                      rvalid_o,
    output logic [BusWidth-1:0]       rdata_o,
    output logic [32*DataCount-1:0]   data_o,
    output logic                      halted_o,
    output logic                      resumeack_o,
    output logic                      cmdbusy_o,
    output logic                      cmd_done_o,
    output logic                      cmd_err_o
);

    localparam int unsigned ProgBufBase = DataAddr - 4 * ProgBufSize;
    localparam int unsigned AbsCmdBase  = ProgBufBase - 4 * AbsCmdWords;
    localparam int unsigned FlagsAddr   = 'h400;
    localparam logic [20:0] JalImm      = 21'(AbsCmdBase - 'h300);
    localparam logic [31:0] WhereToInsn = {JalImm[20], JalImm[10:1], JalImm[11], JalImm[19:12],
                                           5'b0, 7'h6F};

    typedef enum logic [1:0] {StIdle, StGo, StExec} state_e;

    state_e      r_state, w_state_next;
    logic        w_go_set, w_cmd_done, w_cmd_err;
    logic        r_halted, r_resume, r_go;
    logic        r_rvalid, r_resumeack, r_cmd_done, r_cmd_err;
    logic [31:0] r_data [DataCount];
    logic [BusWidth-1:0] r_rdata, w_rdata;
    logic [BusWidth-1:0] w_wr_word, w_rd_data_word, w_rd_prog_word, w_rd_abs_word;

    // Word offsets relative to each window; out-of-window addresses match no word.
    assign w_wr_word      = (wr_data_addr_i - BusWidth'(DataAddr)) >> 2;
    assign w_rd_data_word = (rd_addr_i - BusWidth'(DataAddr)) >> 2;
    assign w_rd_prog_word = (rd_addr_i - BusWidth'(ProgBufBase)) >> 2;
    assign w_rd_abs_word  = (rd_addr_i - BusWidth'(AbsCmdBase)) >> 2;

    always_comb begin
        w_state_next = r_state;
        w_go_set     = 1'b0;
        w_cmd_done   = 1'b0;
        w_cmd_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd_go_i && r_halted) begin
                    w_state_next = StGo;
                    w_go_set     = 1'b1;
                end
            end
            StGo: begin
                if (wr_exception_en) begin
                    w_state_next = StIdle;
                    w_cmd_err    = 1'b1;
                end else if (wr_going_en) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (wr_exception_en) begin
                    w_state_next = StIdle;
                    w_cmd_err    = 1'b1;
                end else if (wr_halted_en) begin
                    w_state_next = StIdle;
                    w_cmd_done   = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (rd_where_en) begin
            w_rdata = BusWidth'(WhereToInsn);
        end
        if (rd_data_en) begin
            for (int i = 0; i < DataCount; i++) begin
                if (w_rd_data_word == BusWidth'(i)) w_rdata = BusWidth'(r_data[i]);
            end
        end
        if (rd_prog_en) begin
            for (int i = 0; i < ProgBufSize; i++) begin
                if (w_rd_prog_word == BusWidth'(i)) w_rdata = BusWidth'(progbuf_i[32*i +: 32]);
            end
        end
        if (rd_abs_cmd_en) begin
            for (int i = 0; i < AbsCmdWords; i++) begin
                if (w_rd_abs_word == BusWidth'(i)) w_rdata = BusWidth'(abs_cmd_i[32*i +: 32]);
            end
        end
        if (rd_flags_en && ((rd_addr_i >> 2) == BusWidth'(FlagsAddr >> 2))) begin
            w_rdata = BusWidth'({30'b0, r_resume, r_go});
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_halted    <= 1'b0;
            r_resume    <= 1'b0;
            r_go        <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_resumeack <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_cmd_err   <= 1'b0;
            for (int i = 0; i < DataCount; i++) r_data[i] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rvalid    <= req_i;
            r_rdata     <= req_i ? w_rdata : '0;
            r_resumeack <= wr_resuming_en;
            r_cmd_done  <= w_cmd_done;
            r_cmd_err   <= w_cmd_err;
            if (wr_halted_en) begin
                r_halted <= 1'b1;
            end else if (wr_resuming_en) begin
                r_halted <= 1'b0;
            end
            if (wr_resuming_en) begin
                r_resume <= 1'b0;
            end else if (resumereq_i && r_halted) begin
                r_resume <= 1'b1;
            end
            if (wr_going_en || w_cmd_err) begin
                r_go <= 1'b0;
            end else if (w_go_set) begin
                r_go <= 1'b1;
            end
            // Hart write to a word shadows a same-cycle debugger write to that word.
            for (int i = 0; i < DataCount; i++) begin
                if (wr_data_en && (w_wr_word == BusWidth'(i))) begin
                    r_data[i] <= 32'(wdata_i);
                end else if (dmi_data_we_i && (dmi_data_idx_i == IdxW'(i))) begin
                    r_data[i] <= dmi_wdata_i;
                end
            end
        end
    end

    for (genvar g = 0; g < DataCount; g++) begin : g_data_out
        assign data_o[32*g +: 32] = r_data[g];
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign halted_o    = r_halted;
    assign resumeack_o = r_resumeack;
    assign cmdbusy_o   = (r_state != StIdle);
    assign cmd_done_o  = r_cmd_done;
    assign cmd_err_o   = r_cmd_err;

endmodule

// File: doc/dm_mem_resp.md
# dm_mem_resp

Response and state stage of the debug-memory slave, directly downstream of the debug-memory address decoder. It consumes the decoder's one-hot write/read enables and pass-through request, and holds the hart-side handshake state (halted, go, resume, exception) and the abstract-command FSM. It owns the `data` registers and returns registered read data one cycle after each request. Its status and command outputs go to the DMI-side debug module registers.

## Interface
Parameters:
- `BusWidth`, 32, data/address width
- `DataCount`, 2, number of 32-bit `data` registers
- `ProgBufSize`, 8, program-buffer words
- `AbsCmdWords`, 10, abstract-command words
- `DataAddr`, 'h380, base of `data` window

Ports:
- `clk_i` in 1: clock; single clock domain
- `rst_i` in 1: reset, asynchronous, active-high
- `req_i` in 1: request pass-through from the decoder
- `wr_halted_en`, `wr_going_en`, `wr_resuming_en`, `wr_exception_en`, `wr_data_en` in 1 each: decoded hart writes
- `wr_data_addr_i` in BusWidth: address of the `data` write
- `wdata_i` in BusWidth: hart write data
- `rd_where_en`, `rd_data_en`, `rd_prog_en`, `rd_abs_cmd_en`, `rd_flags_en` in 1 each: decoded reads
- `rd_addr_i` in BusWidth: read address
- `cmd_go_i` in 1: start abstract command (pulse)
- `resumereq_i` in 1: debugger resume request (pulse)
- `dmi_data_we_i` in 1: debugger write to a `data` word
- `dmi_data_idx_i` in $clog2(DataCount): debugger word index
- `dmi_wdata_i` in 32: debugger write data
- `progbuf_i` in 32*ProgBufSize: program buffer, word 0 in LSBs
- `abs_cmd_i` in 32*AbsCmdWords: generated abstract-command words
- `rvalid_o` out 1: response valid
- `rdata_o` out BusWidth: read data
- `data_o` out 32*DataCount: `data` register contents
- `halted_o` out 1: hart halted
- `resumeack_o` out 1: pulse when the hart acknowledges resume
- `cmdbusy_o` out 1: abstract command in progress
- `cmd_done_o` out 1: pulse, command completed
- `cmd_err_o` out 1: pulse, command raised an exception

## Operation
Derived addresses:
- ProgBufBase = DataAddr − 4·ProgBufSize, 'h360 with defaults.
- AbsCmdBase = ProgBufBase − 4·AbsCmdWords, 'h338 with defaults.
- WhereTo is 'h300. Flags window is 'h400–'h7FF.

Hart state registers:
- `halted_q`: set by `wr_halted_en`, cleared by `wr_resuming_en`.
- `resume_q`: set by `resumereq_i` only when `halted_q`=1. Cleared by `wr_resuming_en`.
- `go_q`: set on the FSM IDLE→GO transition, cleared by `wr_going_en`.

Command FSM:
- IDLE → GO when `cmd_go_i` and `halted_q`. `cmd_go_i` is ignored when not halted or when not in IDLE.
- GO → EXEC on `wr_going_en`.
- EXEC → IDLE on `wr_halted_en`; pulse `cmd_done_o`.
- GO or EXEC → IDLE on `wr_exception_en`; pulse `cmd_err_o`, clear `go_q`. Exception takes priority over halted in the same cycle.
- `wr_exception_en` in IDLE has no effect.
- `cmdbusy_o` = (state ≠ IDLE).

Data registers:
- Word index for hart writes = (`wr_data_addr_i` − DataAddr) >> 2.
- When the hart and the DMI write the same word in the same cycle, the hart write wins. When they target different words, both writes occur.

Read mux, registered:
- where-to: jal x0, (AbsCmdBase − 'h300). Encoding is {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0, 7'h6F}; 'h0380006F with defaults.
- data: `data_q`[index].
- prog: `progbuf_i` word (addr − ProgBufBase) >> 2.
- abs_cmd: `abs_cmd_i` word (addr − AbsCmdBase) >> 2.
- flags: the word at 'h400 returns {30'b0, `resume_q`, `go_q`}. Any other flags address returns 0.
- Writes, and reads with no enable set, return 0.
- Address bits [1:0] are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `data_q`, `halted_q`, `go_q` and `resume_q` all 0. Reset mid-command returns to IDLE with no done or error pulse.
- `rvalid_o` equals `req_i` delayed by 1 cycle, for both reads and writes. `rdata_o` is valid in that cycle and is 0 otherwise.
- Register updates from a request at cycle N are visible on the outputs at N+1. A read at N+1 returns the updated value.
- Read-after-write in the same cycle cannot occur; the decoder allows one access per cycle.
- `resumeack_o` and `cmd_done_o`/`cmd_err_o` are 1-cycle pulses registered at N+1 after the triggering write.
- `resumereq_i` and `wr_resuming_en` in the same cycle: the clear wins, and `resume_q` stays 0.

## Test plan
- Reset, then read 'h300 → `rvalid_o` 1 cycle later, `rdata_o`='h0380006F. All state outputs are 0.
- Write 'h100 (halted) → `halted_o`=1. `cmd_go_i` → read 'h400 returns 1. Write 'h108 → flags read returns 0 and `cmdbusy_o`=1. Write 'h100 → `cmd_done_o` pulse, `cmdbusy_o`=0.
- Halted, command in EXEC, write 'h118 → `cmd_err_o` pulse, state IDLE, `cmd_done_o` stays 0.
- Halted, `resumereq_i` → flags read returns 2. Write 'h110 → `resumeack_o` pulse, `halted_o`=0. `resumereq_i` while not halted → no effect.
- Hart writes 'h384 with 'hDEADBEEF while the DMI writes index 1 with 'h1234 in the same cycle → `data_o` word 1 = 'hDEADBEEF. Read 'h384 returns 'hDEADBEEF.
- Read 'h360 and 'h338 → `progbuf_i` word 0 and `abs_cmd_i` word 0. Read 'h404 → 0. Assert `rst_i` during GO → all outputs 0 asynchronously.
